memory_register_file: RTL and testbench

Parametrised multi-entry storage array for the cache memory subsystem: DEPTH slots of WIDTH bits, each with a valid bit, accessed through a single indexed command port. It supports read, write, delete and a multi-cycle flush. It also tracks occupancy and offers the lowest free slot to the allocating controller. It sits between the cache controller FSM and the key/value storage.

---
 rtl/memory_pkg.sv | 25 ++
 rtl/memory_entry.sv | 39 +++
 rtl/memory_register_file.sv | 157 +++++++++++++++
 tb/tb_memory_register_file.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_pkg                                                           |
// | Command and state encodings shared by the register-file slice.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package memory_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_READ   = 3'd1,
    OP_WRITE  = 3'd2,
    OP_DELETE = 3'd3,
    OP_FLUSH  = 3'd4
  } mem_op_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } mem_state_e;

  localparam int c_OP_W = 3;

endpackage
`default_nettype wire

// File: rtl/memory_entry.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_entry                                                         |
// | One storage slot: a data word plus its valid bit, falling-edge clk.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module memory_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (clr) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (set) begin
      r_data  <= data_in;
      r_valid <= 1'b1;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;

endmodule
`default_nettype wire

// File: rtl/memory_register_file.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_register_file                                                 |
// | Indexed slot array with read/write/delete/flush and free-slot scan.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module memory_register_file
  import memory_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [IDX_W-1:0] op_index,
  input  logic [WIDTH-1:0] op_data,
  output logic             op_ready,
  output logic             rd_valid,
  output logic             rd_hit,
  output logic [WIDTH-1:0] rd_data,
  output logic             err,
  output logic [CNT_W-1:0] count,
  output logic [IDX_W-1:0] free_index,
  output logic             full,
  output logic             empty
);

  localparam logic [IDX_W:0]   c_DEPTH_IDX = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] c_LAST      = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

  mem_state_e       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  logic [DEPTH-1:0] w_valid, w_set, w_clr;
  logic [WIDTH-1:0] w_data [DEPTH];

  logic w_accept, w_in_range, w_is_cmd;
  logic w_is_read, w_is_write, w_is_delete, w_is_flush;
  logic w_sel_valid, w_ptr_valid, w_inc, w_dec, w_err;
  logic [WIDTH-1:0] w_sel_data;
  logic [IDX_W-1:0] w_free;

  assign w_accept    = op_valid && (r_state == ST_IDLE);
  assign w_in_range  = {1'b0, op_index} < c_DEPTH_IDX;
  assign w_is_read   = w_accept && (op_code == OP_READ);
  assign w_is_write  = w_accept && (op_code == OP_WRITE);
  assign w_is_delete = w_accept && (op_code == OP_DELETE);
  assign w_is_flush  = w_accept && (op_code == OP_FLUSH);
  assign w_is_cmd    = w_is_read || w_is_write || w_is_delete || w_is_flush;

  // Index muxes built as compare loops so a non-power-of-two DEPTH never indexes past the array.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    w_ptr_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (op_index == IDX_W'(i)) begin
        w_sel_valid = w_valid[i];
        w_sel_data  = w_data[i];
      end
      if (r_ptr == IDX_W'(i)) begin
        w_ptr_valid = w_valid[i];
      end
    end
  end

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      assign w_set[g] = w_is_write && (op_index == IDX_W'(g));
      assign w_clr[g] = (w_is_delete && (op_index == IDX_W'(g)) && w_valid[g]) ||
                        ((r_state == ST_FLUSH) && (r_ptr == IDX_W'(g)));

      memory_entry #(.WIDTH(WIDTH)) u_entry (
        .clk       (clk),
        .rst_n     (rst_n),
        .set       (w_set[g]),
        .clr       (w_clr[g]),
        .data_in   (op_data),
        .data_out  (w_data[g]),
        .valid_out (w_valid[g])
      );
    end
  endgenerate

  assign w_err = (w_is_cmd && !w_in_range) || (w_is_delete && w_in_range && !w_sel_valid);
  assign w_inc = w_is_write && w_in_range && !w_sel_valid;
  assign w_dec = (w_is_delete && w_in_range && w_sel_valid) ||
                 ((r_state == ST_FLUSH) && w_ptr_valid);

  always_comb begin
    w_count_nxt = r_count;
    if (w_inc) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_dec) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_count  <= '0;
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
      rd_data  <= '0;
      err      <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      rd_valid <= w_is_read;
      rd_hit   <= w_is_read && w_in_range && w_sel_valid;
      rd_data  <= (w_is_read && w_in_range && w_sel_valid) ? w_sel_data : '0;
      err      <= w_err;
      case (r_state)
        ST_IDLE: begin
          if (w_is_flush && w_in_range) begin
            r_state <= ST_FLUSH;
            r_ptr   <= '0;
          end
        end
        ST_FLUSH: begin
          if (r_ptr == c_LAST) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + IDX_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_free = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!w_valid[i]) begin
        w_free = IDX_W'(i);
      end
    end
  end

  assign op_ready   = (r_state == ST_IDLE);
  assign count      = r_count;
  assign free_index = w_free;
  assign full       = (r_count == c_DEPTH_CNT);
  assign empty      = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_memory_register_file.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_memory_register_file                                              |
// | Vector table plus read scoreboard for the slot array.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_memory_register_file;

  logic        clk;
  logic        rst_n;

  logic        a_valid;
  logic [2:0]  a_code;
  logic [2:0]  a_idx;
  logic [31:0] a_data;
  logic        a_op_ready, a_rd_valid, a_rd_hit, a_err, a_full, a_empty;
  logic [31:0] a_rd_data;
  logic [3:0]  a_count;
  logic [2:0]  a_free;

  logic        b_valid;
  logic [2:0]  b_code;
  logic [2:0]  b_idx;
  logic [31:0] b_data;
  logic        b_op_ready, b_rd_valid, b_rd_hit, b_err, b_full, b_empty;
  logic [31:0] b_rd_data;
  logic [2:0]  b_count;
  logic [2:0]  b_free;

  memory_register_file dut_a (
    .clk(clk), .rst_n(rst_n), .op_valid(a_valid), .op_code(a_code), .op_index(a_idx),
    .op_data(a_data), .op_ready(a_op_ready), .rd_valid(a_rd_valid), .rd_hit(a_rd_hit),
    .rd_data(a_rd_data), .err(a_err), .count(a_count), .free_index(a_free),
    .full(a_full), .empty(a_empty)
  );

  memory_register_file #(.WIDTH(32), .DEPTH(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .op_valid(b_valid), .op_code(b_code), .op_index(b_idx),
    .op_data(b_data), .op_ready(b_op_ready), .rd_valid(b_rd_valid), .rd_hit(b_rd_hit),
    .rd_data(b_rd_data), .err(b_err), .count(b_count), .free_index(b_free),
    .full(b_full), .empty(b_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        v;
    logic [2:0]  code;
    logic [2:0]  idx;
    logic [31:0] data;
    logic        e_rdv;
    logic        e_hit;
    logic [31:0] e_rd;
    logic        e_err;
    int          e_cnt;
    int          e_free;
  } vec_t;

  typedef struct {
    logic        hit;
    logic [31:0] d;
  } rd_exp_t;

  vec_t    tbl[$];
  rd_exp_t sb[$];
  int      total = 0;
  int      bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [2:0] code, input logic [2:0] idx,
                     input logic [31:0] data, input logic e_rdv, input logic e_hit,
                     input logic [31:0] e_rd, input logic e_err, input int e_cnt,
                     input int e_free);
    vec_t t;
    t.v = v; t.code = code; t.idx = idx; t.data = data;
    t.e_rdv = e_rdv; t.e_hit = e_hit; t.e_rd = e_rd; t.e_err = e_err;
    t.e_cnt = e_cnt; t.e_free = e_free;
    tbl.push_back(t);
  endtask

  task automatic push_rd(input logic hit, input logic [31:0] d);
    rd_exp_t e;
    e.hit = hit;
    e.d   = d;
    sb.push_back(e);
  endtask

  // Advance to just after the next rising edge; any read result produced by dut_a is scored.
  task automatic cyc();
    rd_exp_t e;
    @(posedge clk);
    #1;
    if (a_rd_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_read actual=1 required=0");
      end else begin
        e = sb.pop_front();
        chk("sb_rd_hit", {31'd0, a_rd_hit}, {31'd0, e.hit});
        chk("sb_rd_data", a_rd_data, e.d);
      end
    end
  endtask

  task automatic drive_a(input logic v, input logic [2:0] code, input logic [2:0] idx,
                         input logic [31:0] data);
    a_valid = v; a_code = code; a_idx = idx; a_data = data;
  endtask

  initial begin
    int lowcnt;
    rst_n = 1'b0;
    drive_a(1'b0, 3'd0, 3'd0, 32'd0);
    b_valid = 1'b0; b_code = 3'd0; b_idx = 3'd0; b_data = 32'd0;

    #2;
    chk("rst_count", {28'd0, a_count}, 32'd0);
    chk("rst_empty", {31'd0, a_empty}, 32'd1);
    chk("rst_full", {31'd0, a_full}, 32'd0);
    chk("rst_free", {29'd0, a_free}, 32'd0);
    chk("rst_ready", {31'd0, a_op_ready}, 32'd1);
    chk("rst_rd_valid", {31'd0, a_rd_valid}, 32'd0);
    chk("rst_err", {31'd0, a_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Six-slot instance: out-of-range index with one slot populated.
    b_valid = 1'b1; b_code = 3'd2; b_idx = 3'd1; b_data = 32'h1111_0001;
    cyc();
    chk("b_write_count", {29'd0, b_count}, 32'd1);
    b_code = 3'd1; b_idx = 3'd7;
    cyc();
    chk("b_oor_err", {31'd0, b_err}, 32'd1);
    chk("b_oor_rd_valid", {31'd0, b_rd_valid}, 32'd1);
    chk("b_oor_rd_hit", {31'd0, b_rd_hit}, 32'd0);
    chk("b_oor_rd_data", b_rd_data, 32'd0);
    chk("b_oor_count", {29'd0, b_count}, 32'd1);
    b_code = 3'd2; b_idx = 3'd6; b_data = 32'hBAD0_0006;
    cyc();
    chk("b_oor_wr_err", {31'd0, b_err}, 32'd1);
    chk("b_oor_wr_count", {29'd0, b_count}, 32'd1);
    chk("b_oor_wr_free", {29'd0, b_free}, 32'd0);
    b_valid = 1'b0;
    cyc();
    chk("b_err_pulse_end", {31'd0, b_err}, 32'd0);

    //  v  code idx data          rdv hit rd_exp        err cnt free
    add(1, 3'd2, 3'd2, 32'hDEADBEEF, 0, 0, 32'h0,        0, 1, 0);
    add(1, 3'd1, 3'd2, 32'h0,        1, 1, 32'hDEADBEEF, 0, 1, 0);
    add(1, 3'd2, 3'd0, 32'h100,      0, 0, 32'h0,        0, 2, 1);
    add(1, 3'd2, 3'd1, 32'h101,      0, 0, 32'h0,        0, 3, 3);
    add(1, 3'd2, 3'd2, 32'h102,      0, 0, 32'h0,        0, 3, 3);
    add(1, 3'd2, 3'd3, 32'h103,      0, 0, 32'h0,        0, 4, 4);
    add(1, 3'd2, 3'd4, 32'h104,      0, 0, 32'h0,        0, 5, 5);
    add(1, 3'd2, 3'd5, 32'h105,      0, 0, 32'h0,        0, 6, 6);
    add(1, 3'd2, 3'd6, 32'h106,      0, 0, 32'h0,        0, 7, 7);
    add(1, 3'd2, 3'd7, 32'h107,      0, 0, 32'h0,        0, 8, 0);
    add(1, 3'd2, 3'd3, 32'hCAFEF00D, 0, 0, 32'h0,        0, 8, 0);
    add(1, 3'd1, 3'd3, 32'h0,        1, 1, 32'hCAFEF00D, 0, 8, 0);
    add(1, 3'd1, 3'd2, 32'h0,        1, 1, 32'h102,      0, 8, 0);
    add(1, 3'd3, 3'd0, 32'h0,        0, 0, 32'h0,        0, 7, 0);
    add(1, 3'd3, 3'd0, 32'h0,        0, 0, 32'h0,        1, 7, 0);
    add(0, 3'd0, 3'd0, 32'h0,        0, 0, 32'h0,        0, 7, 0);
    add(1, 3'd1, 3'd0, 32'h0,        1, 0, 32'h0,        0, 7, 0);
    add(1, 3'd3, 3'd1, 32'h0,        0, 0, 32'h0,        0, 6, 0);
    add(1, 3'd3, 3'd2, 32'h0,        0, 0, 32'h0,        0, 5, 0);
    add(1, 3'd3, 3'd3, 32'h0,        0, 0, 32'h0,        0, 4, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive_a(tbl[i].v, tbl[i].code, tbl[i].idx, tbl[i].data);
      if (tbl[i].v && tbl[i].code == 3'd1) push_rd(tbl[i].e_hit, tbl[i].e_rd);
      cyc();
      chk($sformatf("row%0d_rd_valid", i), {31'd0, a_rd_valid}, {31'd0, tbl[i].e_rdv});
      chk($sformatf("row%0d_err", i), {31'd0, a_err}, {31'd0, tbl[i].e_err});
      chk($sformatf("row%0d_count", i), {28'd0, a_count}, tbl[i].e_cnt);
      chk($sformatf("row%0d_free", i), {29'd0, a_free}, tbl[i].e_free);
      chk($sformatf("row%0d_full", i), {31'd0, a_full}, {31'd0, tbl[i].e_cnt == 8});
      chk($sformatf("row%0d_empty", i), {31'd0, a_empty}, {31'd0, tbl[i].e_cnt == 0});
    end

    // Flush with slots 4..7 valid; a WRITE is held throughout.
    drive_a(1'b1, 3'd4, 3'd0, 32'd0);
    cyc();
    chk("flush_ready_low", {31'd0, a_op_ready}, 32'd0);
    drive_a(1'b1, 3'd2, 3'd5, 32'h55);
    lowcnt = 0;
    while (!a_op_ready && lowcnt < 20) begin
      lowcnt++;
      cyc();
    end
    chk("flush_low_cycles", lowcnt, 32'd8);
    chk("flush_count", {28'd0, a_count}, 32'd0);
    chk("flush_empty", {31'd0, a_empty}, 32'd1);
    cyc();
    chk("held_write_count", {28'd0, a_count}, 32'd1);
    chk("held_write_free", {29'd0, a_free}, 32'd0);
    drive_a(1'b1, 3'd1, 3'd5, 32'd0);
    push_rd(1'b1, 32'h55);
    cyc();
    chk("held_write_rd_valid", {31'd0, a_rd_valid}, 32'd1);

    // Second flush aborted by reset.
    drive_a(1'b1, 3'd2, 3'd6, 32'h66);
    cyc();
    drive_a(1'b1, 3'd2, 3'd7, 32'h77);
    cyc();
    chk("pre_flush2_count", {28'd0, a_count}, 32'd3);
    drive_a(1'b1, 3'd4, 3'd0, 32'd0);
    cyc();
    drive_a(1'b0, 3'd0, 3'd0, 32'd0);
    cyc();
    cyc();
    chk("flush2_busy", {31'd0, a_op_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'd0, a_op_ready}, 32'd1);
    chk("abort_count", {28'd0, a_count}, 32'd0);
    chk("abort_empty", {31'd0, a_empty}, 32'd1);
    chk("abort_full", {31'd0, a_full}, 32'd0);
    chk("abort_free", {29'd0, a_free}, 32'd0);
    chk("abort_rd_valid", {31'd0, a_rd_valid}, 32'd0);
    chk("abort_rd_hit", {31'd0, a_rd_hit}, 32'd0);
    chk("abort_rd_data", a_rd_data, 32'd0);
    chk("abort_err", {31'd0, a_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_a(1'b1, 3'd1, 3'd6, 32'd0);
    push_rd(1'b0, 32'd0);
    cyc();
    chk("post_abort_rd_valid", {31'd0, a_rd_valid}, 32'd1);
    drive_a(1'b0, 3'd0, 3'd0, 32'd0);
    cyc();
    chk("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
